// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fulladder_bit.sv
// One-bit full adder assembled from two cascaded half-adder stages.
module fulladder_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1 = x ^ y;
    assign w_c1 = x & y;
    assign s    = w_s1 ^ ci;
    assign w_c2 = w_s1 & ci;
    assign co   = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_psum_next;

    fulladder_bit u_fa (
        .x  (r_ra[0]),
        .y  (r_rb[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // New bit enters at the MSB so the full sum is aligned after WIDTH shifts.
    assign w_psum_next = {w_s, r_psum[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ra    <= a;
                        r_rb    <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_psum  <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_ra    <= r_ra >> 1;
                    r_rb    <= r_rb >> 1;
                    r_carry <= w_co;
                    r_psum  <= w_psum_next;
                    if (r_cnt == LAST_BIT) begin
                        sum     <= w_psum_next;
                        cout    <= w_co;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: the last result the design should be presenting.
    logic [W-1:0] model_sum  = '0;
    logic         model_cout = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full add starting from IDLE; checks busy/done timing, result hold and the final result.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                           input string tag);
        logic [W:0] expv;
        expv = (W+1)'(ta) + (W+1)'(tb_v) + (W+1)'(tc);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        step();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int k = 1; k <= W; k++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== model_sum || cout !== model_cout)
                $display("FAIL %s run[%0d]: busy=%b done=%b sum=%h cout=%b, expected busy=1 done=0 sum=%h cout=%b",
                         tag, k, busy, done, sum, cout, model_sum, model_cout);
            else n_pass++;
            step();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || {cout, sum} !== expv)
            $display("FAIL %s result: done=%b busy=%b cout=%b sum=%h, expected done=1 busy=0 cout=%b sum=%h",
                     tag, done, busy, cout, sum, expv[W], expv[W-1:0]);
        else n_pass++;
        model_sum  = expv[W-1:0];
        model_cout = expv[W];
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== model_sum)
            $display("FAIL %s after_done: done=%b busy=%b sum=%h, expected done=0 busy=0 sum=%h",
                     tag, done, busy, sum, model_sum);
        else n_pass++;
        $display("add %s: a=%h b=%h cin=%b -> sum=%h cout=%b", tag, ta, tb_v, tc, sum, cout);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0)
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        step(); step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
        else n_pass++;
        model_sum = '0; model_cout = 1'b0;
    endtask

    task automatic test_directed();
        run_add(8'h3C, 8'h0F, 1'b0, "3C+0F");
        run_add(8'hFF, 8'h01, 1'b0, "FF+01");
        run_add(8'hFF, 8'hFF, 1'b1, "FF+FF+1");
    endtask

    task automatic test_hold_result();
        run_add(8'h3C, 8'h0F, 1'b0, "hold_pre");
        run_add(8'h10, 8'h20, 1'b0, "hold_10+20");
    endtask

    // start held high: accept points follow from the spec's "one add per W+2 cycles".
    task automatic test_start_held();
        int acc;
        bit exp_busy, exp_done;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();
        acc = 0;
        for (int t = 1; t <= 19; t++) begin
            if (t == 19) start = 1'b0;
            step();
            if (t == acc + W + 2) acc = t;
            exp_busy = (t - acc) < W;
            exp_done = (t - acc) == W;
            n_checks++;
            if (busy !== exp_busy || done !== exp_done || (exp_done && (sum !== 8'h02 || cout !== 1'b0)))
                $display("FAIL start_held E%0d: busy=%b done=%b sum=%h, expected busy=%b done=%b sum=02",
                         t, busy, done, sum, exp_busy, exp_done);
            else n_pass++;
        end
        model_sum = 8'h02; model_cout = 1'b0;
        $display("start_held: sequence of 19 edges checked, final sum=%h", sum);
    endtask

    task automatic test_reset_mid_run();
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0)
            $display("FAIL async_abort: busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
        else n_pass++;
        model_sum = '0; model_cout = 1'b0;
        for (int k = 0; k < 3; k++) step();
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL no_done_after_abort[%0d]: done=%b busy=%b, expected 0 0", k, done, busy);
            else n_pass++;
        end
        run_add(8'h7F, 8'h01, 1'b0, "7F+01");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_add(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_result();
        test_start_held();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
